reg_file_sb: RTL and testbench

//   Parametrised 2-read/2-write register file with per-register busy scoreboard.

---
 rtl/reg_file_sb.sv | 154 +++++++++++++++
 tb/tb_reg_file_sb.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised 2-read / 2-write register file with a per-register
// busy scoreboard, write-collision flag and optional hard-wired zero register.
// Decode reads operands and reserves its destination; writeback writes results
// and releases the busy bit.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read forwarding).
module reg_file_sb #(
  parameter int W    = 8,
  parameter int A    = 2,
  parameter int ZERO = 0
) (
  input  logic              Clk,
  input  logic              ResetN,
  input  logic [A-1:0]      RaddrA,
  input  logic [A-1:0]      RaddrB,
  output logic [W-1:0]      DataOutA,
  output logic [W-1:0]      DataOutB,
  output logic              BusyA,
  output logic              BusyB,
  input  logic              WriteEnA,
  input  logic [A-1:0]      WaddrA,
  input  logic [W-1:0]      DataInA,
  input  logic              WriteEnB,
  input  logic [A-1:0]      WaddrB,
  input  logic [W-1:0]      DataInB,
  input  logic              ReserveEn,
  input  logic [A-1:0]      ReserveAddr,
  output logic [(1<<A)-1:0] BusyVec,
  output logic              Conflict
);

  localparam int unsigned DEPTH = 1 << A;

  logic [W-1:0]     regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic [DEPTH-1:0] wr_a_hit;
  logic [DEPTH-1:0] wr_b_hit;
  logic [DEPTH-1:0] rsv_hit;
  logic             conflict_q;

  // Per-register decode of write/reserve requests; address 0 is masked off
  // when it is the hard-wired zero register.
  always_comb begin
    wr_a_hit = '0;
    wr_b_hit = '0;
    rsv_hit  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!((ZERO != 0) && (i == 0))) begin
        wr_a_hit[i] = WriteEnA  && (WaddrA      == A'(i));
        wr_b_hit[i] = WriteEnB  && (WaddrB      == A'(i));
        rsv_hit[i]  = ReserveEn && (ReserveAddr == A'(i));
      end
    end
  end

  // Scoreboard next state: a write releases, a reserve sets, reserve wins.
  always_comb begin
    busy_nxt = busy;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (wr_a_hit[i] || wr_b_hit[i]) begin
        busy_nxt[i] = 1'b0;
      end
      if (rsv_hit[i]) begin
        busy_nxt[i] = 1'b1;
      end
    end
  end

  // Register storage; port B has priority when both ports hit one register.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (wr_b_hit[i]) begin
          regs[i] <= DataInB;
        end else if (wr_a_hit[i]) begin
          regs[i] <= DataInA;
        end
      end
    end
  end

  // Busy bits and the one-cycle collision flag (flagged even on address 0).
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      busy       <= '0;
      conflict_q <= 1'b0;
    end else begin
      busy       <= busy_nxt;
      conflict_q <= WriteEnA && WriteEnB && (WaddrA == WaddrB);
    end
  end

  assign BusyVec  = busy;
  assign Conflict = conflict_q;

`ifdef REGFILE_BYPASS_EN
  // Read ports with forwarding: an in-flight write supplies the data and its
  // post-edge busy state. Forwarding is held off while reset is asserted
  // since that write never lands.
  always_comb begin
    DataOutA = regs[RaddrA];
    DataOutB = regs[RaddrB];
    BusyA    = busy[RaddrA];
    BusyB    = busy[RaddrB];
    if (ResetN) begin
      if (wr_b_hit[RaddrA]) begin
        DataOutA = DataInB;
      end else if (wr_a_hit[RaddrA]) begin
        DataOutA = DataInA;
      end
      if (wr_b_hit[RaddrB]) begin
        DataOutB = DataInB;
      end else if (wr_a_hit[RaddrB]) begin
        DataOutB = DataInA;
      end
      if (wr_a_hit[RaddrA] || wr_b_hit[RaddrA]) begin
        BusyA = rsv_hit[RaddrA];
      end
      if (wr_a_hit[RaddrB] || wr_b_hit[RaddrB]) begin
        BusyB = rsv_hit[RaddrB];
      end
    end
    if ((ZERO != 0) && (RaddrA == '0)) begin
      DataOutA = '0;
      BusyA    = 1'b0;
    end
    if ((ZERO != 0) && (RaddrB == '0)) begin
      DataOutB = '0;
      BusyB    = 1'b0;
    end
  end
`else
  // Read ports: stored value only, zero register forced to read 0 / not busy.
  always_comb begin
    DataOutA = regs[RaddrA];
    DataOutB = regs[RaddrB];
    BusyA    = busy[RaddrA];
    BusyB    = busy[RaddrB];
    if ((ZERO != 0) && (RaddrA == '0)) begin
      DataOutA = '0;
      BusyA    = 1'b0;
    end
    if ((ZERO != 0) && (RaddrB == '0)) begin
      DataOutB = '0;
      BusyB    = 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed, table-driven bench for reg_file_sb. Two instances share all inputs:
// u0 with ZERO=0 (main checks) and u1 with ZERO=1 (zero-register checks).
module tb_reg_file_sb;

  logic       Clk = 1'b0;
  logic       ResetN;
  logic [1:0] RaddrA, RaddrB, WaddrA, WaddrB, ReserveAddr;
  logic [7:0] DataInA, DataInB;
  logic       WriteEnA, WriteEnB, ReserveEn;

  logic [7:0] d0a, d0b, d1a, d1b;
  logic       b0a, b0b, b1a, b1b, c0, c1;
  logic [3:0] bv0, bv1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clk = ~Clk;

  reg_file_sb #(.W(8), .A(2), .ZERO(0)) u0 (
    .Clk(Clk), .ResetN(ResetN), .RaddrA(RaddrA), .RaddrB(RaddrB),
    .DataOutA(d0a), .DataOutB(d0b), .BusyA(b0a), .BusyB(b0b),
    .WriteEnA(WriteEnA), .WaddrA(WaddrA), .DataInA(DataInA),
    .WriteEnB(WriteEnB), .WaddrB(WaddrB), .DataInB(DataInB),
    .ReserveEn(ReserveEn), .ReserveAddr(ReserveAddr),
    .BusyVec(bv0), .Conflict(c0)
  );

  reg_file_sb #(.W(8), .A(2), .ZERO(1)) u1 (
    .Clk(Clk), .ResetN(ResetN), .RaddrA(RaddrA), .RaddrB(RaddrB),
    .DataOutA(d1a), .DataOutB(d1b), .BusyA(b1a), .BusyB(b1b),
    .WriteEnA(WriteEnA), .WaddrA(WaddrA), .DataInA(DataInA),
    .WriteEnB(WriteEnB), .WaddrB(WaddrB), .DataInB(DataInB),
    .ReserveEn(ReserveEn), .ReserveAddr(ReserveAddr),
    .BusyVec(bv1), .Conflict(c1)
  );

  typedef struct {
    logic       wea;
    logic [1:0] wa;
    logic [7:0] da;
    logic       web;
    logic [1:0] wb;
    logic [7:0] db;
    logic       rse;
    logic [1:0] rsa;
    logic [1:0] ra;
    logic [1:0] rb;
    logic [7:0] exp_da;
    logic [7:0] exp_db;
    logic       exp_ba;
    logic       exp_bb;
    logic [3:0] exp_bv;
    logic       exp_cf;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    WriteEnA = 1'b0; WriteEnB = 1'b0; ReserveEn = 1'b0;
  endtask

  // Watchdog: the sequence is bounded, this only guards against a stuck clock.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // addr/data fields: wea wa da web wb db rse rsa ra rb | da db ba bb bv cf
    vt[0] = '{1'b1, 2'd1, 8'h11, 1'b1, 2'd2, 8'h22, 1'b0, 2'd0, 2'd1, 2'd2, 8'h11, 8'h22, 1'b0, 1'b0, 4'b0000, 1'b0};
    vt[1] = '{1'b1, 2'd3, 8'h33, 1'b1, 2'd3, 8'h44, 1'b0, 2'd0, 2'd3, 2'd1, 8'h44, 8'h11, 1'b0, 1'b0, 4'b0000, 1'b1};
    vt[2] = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd3, 2'd2, 8'h44, 8'h22, 1'b0, 1'b0, 4'b0000, 1'b0};
    vt[3] = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 2'd2, 2'd3, 8'h22, 8'h44, 1'b1, 1'b0, 4'b0100, 1'b0};
    vt[4] = '{1'b1, 2'd2, 8'h5A, 1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 2'd2, 2'd3, 8'h5A, 8'h44, 1'b1, 1'b0, 4'b0100, 1'b0};
    vt[5] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 8'h66, 1'b0, 2'd0, 2'd2, 2'd3, 8'h66, 8'h44, 1'b0, 1'b0, 4'b0000, 1'b0};
    vt[6] = '{1'b1, 2'd3, 8'h99, 1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 2'd1, 2'd3, 8'h11, 8'h99, 1'b1, 1'b0, 4'b0010, 1'b0};
    vt[7] = '{1'b1, 2'd0, 8'h0F, 1'b1, 2'd1, 8'hEE, 1'b1, 2'd3, 2'd0, 2'd1, 8'h0F, 8'hEE, 1'b0, 1'b0, 4'b1000, 1'b0};
    vt[8] = '{1'b1, 2'd0, 8'h01, 1'b1, 2'd0, 8'h02, 1'b0, 2'd0, 2'd0, 2'd3, 8'h02, 8'h99, 1'b0, 1'b1, 4'b1000, 1'b1};
    vt[9] = '{1'b1, 2'd1, 8'hAB, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd1, 2'd3, 8'hAB, 8'h99, 1'b0, 1'b1, 4'b1000, 1'b0};

    // Reset state, checked before any clock edge
    ResetN = 1'b0;
    idle_inputs();
    WaddrA = '0; WaddrB = '0; ReserveAddr = '0;
    DataInA = '0; DataInB = '0;
    RaddrA = 2'd1; RaddrB = 2'd2;
    #1;
    chk("rst_douta", 32'(d0a), 32'h00);
    chk("rst_doutb", 32'(d0b), 32'h00);
    chk("rst_busya", 32'(b0a), 32'h0);
    chk("rst_busyvec", 32'(bv0), 32'h0);
    chk("rst_conflict", 32'(c0), 32'h0);
    repeat (2) @(negedge Clk);
    ResetN = 1'b1;

    // Table: drive at negedge, let the edge pass, drop enables, compare
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      WriteEnA = vt[i].wea; WaddrA = vt[i].wa; DataInA = vt[i].da;
      WriteEnB = vt[i].web; WaddrB = vt[i].wb; DataInB = vt[i].db;
      ReserveEn = vt[i].rse; ReserveAddr = vt[i].rsa;
      RaddrA = vt[i].ra; RaddrB = vt[i].rb;
      @(posedge Clk);
      #1;
      idle_inputs();
      #1;
      chk($sformatf("v%0d_douta", i), 32'(d0a), 32'(vt[i].exp_da));
      chk($sformatf("v%0d_doutb", i), 32'(d0b), 32'(vt[i].exp_db));
      chk($sformatf("v%0d_busya", i), 32'(b0a), 32'(vt[i].exp_ba));
      chk($sformatf("v%0d_busyb", i), 32'(b0b), 32'(vt[i].exp_bb));
      chk($sformatf("v%0d_busyvec", i), 32'(bv0), 32'(vt[i].exp_bv));
      chk($sformatf("v%0d_conflict", i), 32'(c0), 32'(vt[i].exp_cf));
    end

    // Conflict lasts exactly one cycle
    @(posedge Clk); #1;
    chk("conflict_drop", 32'(c0), 32'h0);

    // Zero register: write r0=FF plus reserve r0
    @(negedge Clk);
    WriteEnA = 1'b1; WaddrA = 2'd0; DataInA = 8'hFF;
    ReserveEn = 1'b1; ReserveAddr = 2'd0;
    RaddrA = 2'd0; RaddrB = 2'd3;
    @(posedge Clk); #1; idle_inputs(); #1;
    chk("z1_douta_r0", 32'(d1a), 32'h00);
    chk("z1_busya_r0", 32'(b1a), 32'h0);
    chk("z1_busyvec0", 32'(bv1[0]), 32'h0);
    chk("z0_douta_r0", 32'(d0a), 32'hFF);
    chk("z0_busyvec", 32'(bv0), 32'b1001);

    // Collision on r0 is still flagged with ZERO=1
    @(negedge Clk);
    WriteEnA = 1'b1; WaddrA = 2'd0; DataInA = 8'h01;
    WriteEnB = 1'b1; WaddrB = 2'd0; DataInB = 8'h02;
    @(posedge Clk); #1; idle_inputs(); #1;
    chk("z1_conflict_r0", 32'(c1), 32'h1);
    chk("z1_douta_r0b", 32'(d1a), 32'h00);
    chk("z0_conflict_r0", 32'(c0), 32'h1);
    chk("z0_douta_r0b", 32'(d0a), 32'h02);
    chk("z0_busyvec_b", 32'(bv0), 32'b1000);

    // Read of a register being written this cycle (r1 holds AB, r3 holds 99 and busy)
    @(negedge Clk);
    WriteEnA = 1'b1; WaddrA = 2'd1; DataInA = 8'h77;
    WriteEnB = 1'b1; WaddrB = 2'd3; DataInB = 8'h12;
    RaddrA = 2'd1; RaddrB = 2'd3;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_douta_same", 32'(d0a), 32'h77);
    chk("byp_doutb_same", 32'(d0b), 32'h12);
    chk("byp_busyb_same", 32'(b0b), 32'h0);
`else
    chk("byp_douta_same", 32'(d0a), 32'hAB);
    chk("byp_doutb_same", 32'(d0b), 32'h99);
    chk("byp_busyb_same", 32'(b0b), 32'h1);
`endif
    @(posedge Clk); #1; idle_inputs(); #1;
    chk("byp_douta_next", 32'(d0a), 32'h77);
    chk("byp_doutb_next", 32'(d0b), 32'h12);
    chk("byp_busyb_next", 32'(b0b), 32'h0);
    chk("byp_busyvec", 32'(bv0), 32'h0);

    // Reset mid-write: write r1=AA and reserve r2 while ResetN drops
    @(negedge Clk);
    WriteEnA = 1'b1; WaddrA = 2'd1; DataInA = 8'hAA;
    ReserveEn = 1'b1; ReserveAddr = 2'd2;
    RaddrA = 2'd1; RaddrB = 2'd2;
    ResetN = 1'b0;
    #1;
    chk("mrst_douta_async", 32'(d0a), 32'h00);
    chk("mrst_doutb_async", 32'(d0b), 32'h00);
    @(posedge Clk); #1; idle_inputs(); #1;
    chk("mrst_busyvec", 32'(bv0), 32'h0);
    chk("mrst_conflict", 32'(c0), 32'h0);
    @(negedge Clk);
    ResetN = 1'b1;
    @(posedge Clk); #1;
    chk("mrst_douta_after", 32'(d0a), 32'h00);
    chk("mrst_busyb_after", 32'(b0b), 32'h0);
    chk("mrst_busyvec_after", 32'(bv0), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
